byte_serializer: RTL and testbench
==================================

Name: byte_serializer

Overview:
- Converts one parallel word of blockSize bytes into a little-endian byte stream: least-significant byte first.
- Transmit-side counterpart of the byte deserializer; the two form a matched pair over an 8-bit link.
- Sits between a sample/word producer and a byte-wide consumer such as a UART TX or FIFO write port.
- Ready/valid handshake on both sides; back-to-back blocks stream with no idle cycles.

Parameters:
- blockSize, 2, number of bytes per input word; legal values ≥ 1. Input width is 8*blockSize.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- inValid  input  1  producer has a word on inData.
- inReady  output  1  block can accept a word this cycle.
- inData  input  8*blockSize  word to serialize; bits [7:0] are sent first.
- outValid  output  1  outData holds a valid byte.
- outReady  input  1  consumer takes outData this cycle.
- outData  output  8  current byte.
- outLast  output  1  high with the final byte of each block.

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - outValid=0, outData=0, outLast=0, index=0, shift register=0, state=IDLE.
  - inReady=0 while reset=0.
- States:
  - IDLE: outValid=0.
  - SEND: outValid=1; index selects the current byte, 0..blockSize-1.
- Transfer definitions:
  - Input transfer = inValid & inReady.
  - Output transfer = outValid & outReady.
- inReady = (state==IDLE) | (output transfer with index==blockSize-1). This is a combinational path from outReady; it is allowed and must be documented at integration.
- On input transfer:
  - Capture inData into the shift register.
  - Next cycle: outData=inData[7:0], index=0, state=SEND.
  - Latency: first byte valid 1 cycle after acceptance.
- SEND with output transfer and index<blockSize-1: outData advances to the next byte (shift right by 8); index+1.
- SEND with output transfer and index==blockSize-1:
  - If an input transfer happens in the same cycle, load the new word (previous bullet) and stay in SEND.
  - Otherwise go to IDLE and clear outValid.
  - outData keeps its last value in IDLE.
- Back-pressure: outValid=1 & outReady=0 freezes outData, outLast and index. outValid never drops without a transfer.
- outLast = outValid & (index==blockSize-1).
- Throughput: with outReady held high and inValid continuous, exactly blockSize cycles per block.
- blockSize=1: index width is max(1, $clog2(blockSize)); every byte has outLast=1; inReady is high every cycle that outReady is high.
- inValid while in SEND and not on the last-byte transfer: ignored; the producer must hold inData.
- Reset asserted mid-block: the partial block is discarded with no further bytes. After release, the first byte out belongs to a newly accepted word.
- inData is sampled only on an input transfer.

Optional Feature:
- Macro: BYTE_SERIALIZER_PREFETCH_EN.
- Defined:
  - Adds a one-word holding register with a holdValid flag.
  - inReady = !holdValid, registered; there is no combinational path from outReady.
  - A word accepted while in SEND goes to the holding register.
  - On the last-byte output transfer with holdValid=1, the holding register loads into the shift register and holdValid clears in the same edge.
  - Reset clears holdValid and the holding register.
- Not defined: behaviour exactly as above, with no holding register.

Decomposition:
- Shared package byte_stream_pkg holds:
  - localparam BYTE_W=8.
  - The state enum {IDLE, SEND}.
  - An index-width function clog2_min1(n), shared with the deserializer.
- No sub-module. The holding register is an internal always block under the macro.

Test Plan:
- Reset release, then inValid=1, inData=16'hBEEF, outReady=1 → outData 8'hEF (outLast=0), then 8'hBE (outLast=1), then outValid=0. inReady=1 again on the 8'hBE cycle.
- Back-pressure: outReady=0 for 3 cycles after 8'hEF appears → outData stays 8'hEF and index is frozen. Then outReady=1 → 8'hBE follows.
- Back-to-back words 16'h1234, 16'h5678 with continuous valid/ready → bytes 34,12,78,56 on 4 consecutive cycles, no bubble; outLast on 12 and 56.
- Reset pulse low after byte 8'h34 of 16'h1234 → outValid drops immediately and asynchronously, 8'h12 is never emitted. Next word 16'hA5C3 emits C3,A5.
- blockSize=4, word 32'h04030201 → bytes 01,02,03,04 with outLast only on 04. Feed the outputs to a deserializer with blockSize=4 → reassembled 32'h04030201.
- BYTE_SERIALIZER_PREFETCH_EN defined → second word accepted (inReady=1) during byte 0 of the first. inReady=0 until the hold register drains. Streaming has no bubble.

Source files
------------

// File: rtl/byte_stream_pkg.sv
// Shared definitions for the byte serializer/deserializer pair over an 8-bit link.
package byte_stream_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Index counters need at least one bit even when a block is a single byte.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Word-in / byte-out ready-valid bundle; master drives the producer and consumer side, slave is the serializer.
interface byte_serializer_if #(
    parameter int blockSize = 2
);

    logic                                      inValid;
    logic                                      inReady;
    logic [byte_stream_pkg::BYTE_W*blockSize-1:0] inData;
    logic                                      outValid;
    logic                                      outReady;
    logic [byte_stream_pkg::BYTE_W-1:0]        outData;
    logic                                      outLast;

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outData, outLast
    );

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outData, outLast
    );

endinterface

// File: rtl/byte_serializer.sv
// Little-endian word-to-byte serializer (LSB first) with ready/valid on both sides.
// Define BYTE_SERIALIZER_PREFETCH_EN for a one-word holding register and a registered inReady.
module byte_serializer
    import byte_stream_pkg::*;
#(
    parameter int blockSize = 2
) (
    input  logic             clk,
    input  logic             reset,
    byte_serializer_if.slave bus
);

    localparam int              IdxW    = clog2_min1(blockSize);
    localparam int              WordW   = BYTE_W * blockSize;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(blockSize - 1);
    localparam logic [0:0]      StIdle  = IDLE;
    localparam logic [0:0]      StSend  = SEND;

    logic [0:0]       state_q, state_d;
    logic [IdxW-1:0]  index_q, index_d;
    logic [WordW-1:0] shiftReg_q, shiftReg_d;
    logic             inReady;
    logic             inXfer, outXfer, lastXfer, loadWord;
    logic [WordW-1:0] loadData;

    assign outXfer  = (state_q == StSend) & bus.outReady;
    assign lastXfer = outXfer & (index_q == LastIdx);
    assign inXfer   = bus.inValid & inReady;

`ifdef BYTE_SERIALIZER_PREFETCH_EN
    logic             holdValid_q, holdValid_d;
    logic [WordW-1:0] hold_q, hold_d;
    logic             captureHold;

    // inReady depends only on the hold flag, so no path from outReady reaches it.
    assign inReady     = reset & ~holdValid_q;
    assign captureHold = inXfer & (state_q == StSend) & ~lastXfer;
    assign loadWord    = (inXfer & ~captureHold) | (lastXfer & holdValid_q);
    assign loadData    = holdValid_q ? hold_q : bus.inData;

    always_comb begin
        holdValid_d = holdValid_q;
        hold_d      = hold_q;
        if (captureHold) begin
            holdValid_d = 1'b1;
            hold_d      = bus.inData;
        end else if (lastXfer) begin
            holdValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdValid_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            holdValid_q <= holdValid_d;
            hold_q      <= hold_d;
        end
    end
`else
    // A new word is taken when idle or as the final byte leaves, giving gap-free streaming.
    assign inReady  = reset & ((state_q == StIdle) | lastXfer);
    assign loadWord = inXfer;
    assign loadData = bus.inData;
`endif

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        shiftReg_d = shiftReg_q;
        if (loadWord) begin
            shiftReg_d = loadData;
            index_d    = '0;
            state_d    = StSend;
        end else if (lastXfer) begin
            state_d = StIdle;
        end else if (outXfer) begin
            shiftReg_d = shiftReg_q >> BYTE_W;
            index_d    = index_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            index_q    <= '0;
            shiftReg_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            shiftReg_q <= shiftReg_d;
        end
    end

    assign bus.inReady  = inReady;
    assign bus.outValid = (state_q == StSend);
    assign bus.outData  = shiftReg_q[BYTE_W-1:0];
    assign bus.outLast  = (state_q == StSend) & (index_q == LastIdx);

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: vector table, corner sequences, and a random run against a byte-queue model.
// Covers blockSize 2 and 4; BYTE_SERIALIZER_PREFETCH_EN selects the matching inReady rule.
module tb_byte_serializer;
    import byte_stream_pkg::*;

    typedef struct {
        logic        inValid;
        logic [15:0] inData;
        logic        outReady;
        logic        expValid;
        logic [7:0]  expData;
        logic        expLast;
        logic        expRdy;
        logic        expRdyPf;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    byte_serializer_if #(.blockSize(2)) bus2 ();
    byte_serializer_if #(.blockSize(4)) bus4 ();

    byte_serializer #(.blockSize(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    byte_serializer #(.blockSize(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    vec_t        vecs [16];
    logic [7:0]  byteQ [$];
    bit          lastQ [$];
    logic [31:0] sentQ [$];
    logic [31:0] asm4, word4, expWord;
    logic        curValid, curReady, expValid, expRdy;
    logic [15:0] curData;
    int          n, sentCnt, recvCnt, byteCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r);
        @(posedge clk);
        #1;
        bus2.inValid  = v;
        bus2.inData   = d;
        bus2.outReady = r;
    endtask

    task automatic doReset();
        reset = 1'b0;
        bus2.inValid = 1'b0; bus2.inData = '0; bus2.outReady = 1'b1;
        bus4.inValid = 1'b0; bus4.inData = '0; bus4.outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hBE, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'hBE, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 16'hBEEF, 1'b0, 1'b0, 8'hBE, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hBE, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 16'h1234, 1'b1, 1'b0, 8'hBE, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 16'h5678, 1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 16'h5678, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h78, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h56, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h56, 1'b0, 1'b1, 1'b1};

        reset = 1'b0;
        bus2.inValid = 1'b0; bus2.inData = '0; bus2.outReady = 1'b1;
        bus4.inValid = 1'b0; bus4.inData = '0; bus4.outReady = 1'b1;
        @(negedge clk);
        checkOutput("rst.outValid", bus2.outValid, 0);
        checkOutput("rst.outData", bus2.outData, 0);
        checkOutput("rst.outLast", bus2.outLast, 0);
        checkOutput("rst.inReady", bus2.inReady, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].inData, vecs[i].outReady);
            @(negedge clk);
            checkOutput($sformatf("vec%0d.outValid", i), bus2.outValid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d.outData", i), bus2.outData, vecs[i].expData);
            checkOutput($sformatf("vec%0d.outLast", i), bus2.outLast, vecs[i].expLast);
`ifdef BYTE_SERIALIZER_PREFETCH_EN
            checkOutput($sformatf("vec%0d.inReady", i), bus2.inReady, vecs[i].expRdyPf);
`else
            checkOutput($sformatf("vec%0d.inReady", i), bus2.inReady, vecs[i].expRdy);
`endif
        end

        // Reset in the middle of a block must drop the pending byte 8'h12 for good.
        applyStimulus(1'b1, 16'h1234, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("mid.byte0", bus2.outData, 8'h34);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid.asyncValid", bus2.outValid, 0);
        checkOutput("mid.asyncReady", bus2.inReady, 0);
        checkOutput("mid.asyncData", bus2.outData, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("mid.noResume", bus2.outValid, 0);
        applyStimulus(1'b1, 16'hA5C3, 1'b1);
        @(negedge clk);
        checkOutput("mid.acceptIdle", bus2.outValid, 0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("mid.c3", {bus2.outValid, bus2.outLast, bus2.outData}, {2'b10, 8'hC3});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("mid.a5", {bus2.outValid, bus2.outLast, bus2.outData}, {2'b11, 8'hA5});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("mid.idle", bus2.outValid, 0);

`ifdef BYTE_SERIALIZER_PREFETCH_EN
        applyStimulus(1'b1, 16'h1234, 1'b1);
        applyStimulus(1'b1, 16'h5678, 1'b1);
        @(negedge clk);
        checkOutput("pf.readyByte0", {bus2.inReady, bus2.outData}, {1'b1, 8'h34});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("pf.heldByte1", {bus2.inReady, bus2.outData}, {1'b0, 8'h12});
        applyStimulus(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("pf.drained", {bus2.inReady, bus2.outValid, bus2.outData}, {2'b11, 8'h78});
`endif

        // Random traffic: the model is a FIFO of bytes still owed, tagged with their last flag.
        doReset();
        byteQ.delete();
        lastQ.delete();
        for (int cyc = 0; cyc < 500; cyc++) begin
            curValid = 1'($urandom_range(0, 1));
            curData  = 16'($urandom);
            curReady = ($urandom_range(0, 3) != 0);
            applyStimulus(curValid, curData, curReady);
            @(negedge clk);
            n        = byteQ.size();
            expValid = (n > 0);
`ifdef BYTE_SERIALIZER_PREFETCH_EN
            expRdy = (n <= 2);
`else
            expRdy = (n == 0) || (n == 1 && curReady);
`endif
            checkOutput("rnd.outValid", bus2.outValid, expValid);
            checkOutput("rnd.inReady", bus2.inReady, expRdy);
            if (expValid) begin
                checkOutput("rnd.outData", bus2.outData, byteQ[0]);
                checkOutput("rnd.outLast", bus2.outLast, lastQ[0]);
                if (curReady) begin
                    void'(byteQ.pop_front());
                    void'(lastQ.pop_front());
                end
            end
            if (curValid && expRdy) begin
                for (int b = 0; b < 2; b++) begin
                    byteQ.push_back(curData[8*b +: 8]);
                    lastQ.push_back(b == 1);
                end
            end
        end

        // Four-byte blocks reassembled by a behavioural deserializer.
        doReset();
        @(posedge clk);
        #1;
        bus4.inValid  = 1'b1;
        bus4.inData   = 32'h04030201;
        bus4.outReady = 1'b1;
        @(negedge clk);
        checkOutput("bs4.acceptIdle", bus4.inReady, 1);
        @(posedge clk);
        #1 bus4.inValid = 1'b0;
        asm4 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bs4.byte%0d", k), {bus4.outValid, bus4.outLast, bus4.outData},
                        {1'b1, (k == 3) ? 1'b1 : 1'b0, 8'(k + 1)});
            asm4[8*k +: 8] = bus4.outData;
        end
        checkOutput("bs4.reassembled", asm4, 32'h04030201);
        @(negedge clk);
        checkOutput("bs4.idle", bus4.outValid, 0);

        sentCnt = 0;
        recvCnt = 0;
        byteCnt = 0;
        word4   = $urandom;
        for (int cyc = 0; cyc < 3000 && recvCnt < 20; cyc++) begin
            @(posedge clk);
            #1;
            bus4.inValid  = (sentCnt < 20);
            bus4.inData   = word4;
            bus4.outReady = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus4.inValid && bus4.inReady) begin
                sentQ.push_back(word4);
                sentCnt++;
                word4 = $urandom;
            end
            if (bus4.outValid && bus4.outReady) begin
                if (byteCnt < 4) asm4[8*byteCnt +: 8] = bus4.outData;
                byteCnt++;
                if (bus4.outLast) begin
                    expWord = (sentQ.size() > 0) ? sentQ.pop_front() : 32'hXXXXXXXX;
                    checkOutput("bs4.lastPos", byteCnt, 4);
                    checkOutput("bs4.word", asm4, expWord);
                    recvCnt++;
                    byteCnt = 0;
                end
            end
        end
        checkOutput("bs4.completed", recvCnt, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
